glitch_sequencer: RTL and testbench
===================================

# glitch_sequencer

Multi-channel, parametrised successor to the single-output glitch controller. It holds per-channel delay, width, repeat-count and repeat-gap registers. After a qualifying trigger edge it fires an independent pulse train on each of N_CH glitch outputs, so crowbar, clock-glitch and power-cut outputs can be timed against one trigger. It sits between the UART command decoder, which drives the config write port and arm level, and the output mux, all in the `sysclk` domain.

## Interface
- `CTR_W`, 32, width of delay/width/gap/edge/timeout counters and `cfg_wdata`
- `N_CH`, 4, number of glitch channels (1..8)
- `RPT_W`, 16, width of per-channel repeat count
- `sysclk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `i_arm`  in  1  level; high = armed request, low = disarm/abort
- `i_trig`  in  1  raw asynchronous target trigger
- `cfg_we`  in  1  config write strobe, one cycle
- `cfg_ch`  in  3  channel index for per-channel registers
- `cfg_sel`  in  3  register select (see Operation)
- `cfg_wdata`  in  CTR_W  write data
- `o_glitch`  out  N_CH  per-channel glitch pulse
- `o_state`  out  2  0 IDLE, 1 ARMED, 2 RUNNING, 3 DONE
- `o_cfg_err`  out  1  one-cycle pulse on rejected write
- `o_timeout`  out  1  one-cycle pulse on arm timeout (only with the macro)

## Operation
- Register select values:
  - 0 DELAY[ch], 1 WIDTH[ch], 2 RPT[ch] (low RPT_W bits), 3 GAP[ch]: per channel.
  - 4 EDGE_TGT, 5 TRIG_CFG, 6 TIMEOUT: global; `cfg_ch` is ignored.
  - TRIG_CFG bit0 inverts the trigger. Bit1 selects manual fire, which ignores the trigger.
- Reject a write (pulse `o_cfg_err`, leave the register unchanged) on any of:
  - `cfg_sel`=7;
  - `cfg_ch`>=N_CH with `cfg_sel`<=3;
  - state not IDLE.
- Trigger path: 2-FF synchroniser, then an edge-detect register. Qualifying edge = rising edge of the (optionally inverted) synchronised trigger.
- Global FSM:
  - IDLE→ARMED when `i_arm`=1; the edge counter clears.
  - In ARMED, each qualifying edge increments the edge counter. When the edge count equals EDGE_TGT, go to RUNNING: edge number EDGE_TGT+1 fires. With manual fire set, go ARMED→RUNNING on the first ARMED cycle.
  - RUNNING→DONE when every channel is finished.
  - DONE holds, with all outputs low, until `i_arm`=0 (one shot per arm).
  - Any state→IDLE when `i_arm`=0.
- Channel FSM (WAIT, FIRE, GAP, FIN), loaded on entry to RUNNING:
  - A channel with WIDTH=0 is FIN immediately.
  - WAIT: DELAY cycles, then FIRE.
  - FIRE: `o_glitch[ch]`=1 for WIDTH cycles. Then GAP if pulses emitted ≤ RPT, else FIN.
  - GAP: output low for GAP+1 cycles, then FIRE.
  - Total pulses per channel = RPT+1.
- Counters compare for equality and never wrap. All registers are unsigned.

## Timing
- Reset value: all outputs 0, `o_state`=IDLE, all config registers 0, counters 0.
- With the edge-detect output high at cycle T (the transition cycle), `o_state`=RUNNING from T+1. `o_glitch[ch]` is high in cycles T+1+DELAY through T+DELAY+WIDTH inclusive.
- Input to edge-detect latency is 3 `sysclk` cycles. Trigger pulses shorter than 2 cycles may be missed.
- `i_arm` low takes effect next cycle: `o_glitch` goes to 0 and `o_state` to IDLE, even mid-pulse.
- A qualifying edge during RUNNING or DONE is ignored.
- Channels run independently; overlapping pulses on different channels are allowed.
- `o_state`=DONE the cycle after the last channel reaches FIN.
- `o_cfg_err` is asserted the cycle after the rejected `cfg_we`.

## Configuration
- `GLITCH_SEQ_TIMEOUT_EN` defined:
  - ARMED runs a cycle counter. When it reaches TIMEOUT (TIMEOUT≠0), pulse `o_timeout` for one cycle and go to DONE without firing.
  - TIMEOUT=0 disables the timeout.
- Undefined: no timeout counter. `o_timeout` is tied 0. Writes to sel 6 are accepted and have no effect.

## Test plan
- Single channel: DELAY=5, WIDTH=3, RPT=0, EDGE_TGT=0, one `i_trig` pulse → `o_glitch[0]` high for cycles T+6..T+8, then DONE at T+9.
- Repeat: ch1 WIDTH=2, RPT=2, GAP=1 → three 2-cycle pulses separated by 2 low cycles, exactly 3 pulses.
- Edge count plus invert: EDGE_TGT=2, TRIG_CFG=1, four falling edges on `i_trig` → fires on the third falling edge only; the fourth is ignored.
- Abort: drop `i_arm` during ch0 FIRE with WIDTH=100 → output low and IDLE next cycle. Re-arm re-fires on the next trigger.
- Config errors: write while ARMED, and write with `cfg_ch`=N_CH → `o_cfg_err` pulses and readback behaviour is unchanged.
- With `GLITCH_SEQ_TIMEOUT_EN`: TIMEOUT=50, no trigger → `o_timeout` pulses 50 cycles after ARMED, state DONE, no glitch output.

Source files
------------

// File: rtl/glitch_sequencer_if.sv
// Config/trigger/output bundle between the UART command decoder, the glitch
// sequencer and the output mux.
interface glitch_sequencer_if #(
    parameter int CTR_W = 32,
    parameter int N_CH  = 4
);
    logic             i_arm;
    logic             i_trig;
    logic             cfg_we;
    logic [2:0]       cfg_ch;
    logic [2:0]       cfg_sel;
    logic [CTR_W-1:0] cfg_wdata;
    logic [N_CH-1:0]  o_glitch;
    logic [1:0]       o_state;
    logic             o_cfg_err;
    logic             o_timeout;

    modport master (
        output i_arm, i_trig, cfg_we, cfg_ch, cfg_sel, cfg_wdata,
        input  o_glitch, o_state, o_cfg_err, o_timeout
    );

    modport slave (
        input  i_arm, i_trig, cfg_we, cfg_ch, cfg_sel, cfg_wdata,
        output o_glitch, o_state, o_cfg_err, o_timeout
    );
endinterface

// File: rtl/glitch_sequencer.sv
// Multi-channel triggered glitch pulse-train generator, one shot per arm.
// Define GLITCH_SEQ_TIMEOUT_EN to compile in the ARMED-state timeout.
module glitch_sequencer #(
    parameter int CTR_W = 32,
    parameter int N_CH  = 4,
    parameter int RPT_W = 16
) (
    input  logic              sysclk,
    input  logic              rst,
    glitch_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {CH_WAIT, CH_FIRE, CH_GAP, CH_FIN} ch_state_t;

    localparam logic [2:0] SEL_DELAY    = 3'd0;
    localparam logic [2:0] SEL_WIDTH    = 3'd1;
    localparam logic [2:0] SEL_RPT      = 3'd2;
    localparam logic [2:0] SEL_GAP      = 3'd3;
    localparam logic [2:0] SEL_EDGE_TGT = 3'd4;
    localparam logic [2:0] SEL_TRIG_CFG = 3'd5;
    localparam logic [2:0] SEL_TIMEOUT  = 3'd6;

    // Configuration registers
    logic [CTR_W-1:0] delay_r [N_CH];
    logic [CTR_W-1:0] width_r [N_CH];
    logic [CTR_W-1:0] gap_r   [N_CH];
    logic [RPT_W-1:0] rpt_r   [N_CH];
    logic [CTR_W-1:0] edge_tgt_r;
    logic             trig_inv_r;
    logic             manual_r;
    logic             cfg_reject;
    logic             cfg_err_q;

    // Sequencing state
    state_t           state, state_nxt;
    logic [CTR_W-1:0] edge_cnt, edge_cnt_nxt;
    logic             trig_s1, trig_s2, trig_q, trig_x, edge_q;
    logic             start;
    logic             all_fin_nxt;
    logic [N_CH-1:0]  glitch;

    ch_state_t        ch_st      [N_CH];
    ch_state_t        ch_st_nxt  [N_CH];
    logic [CTR_W-1:0] ch_cnt     [N_CH];
    logic [CTR_W-1:0] ch_cnt_nxt [N_CH];
    logic [RPT_W-1:0] ch_pcnt    [N_CH];
    logic [RPT_W-1:0] ch_pcnt_nxt[N_CH];

`ifdef GLITCH_SEQ_TIMEOUT_EN
    logic [CTR_W-1:0] timeout_r;
    logic [CTR_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             timeout_q, timeout_nxt;
`endif

    assign cfg_reject = (bus.cfg_sel == 3'd7)
                     || ((bus.cfg_sel <= SEL_GAP) && (int'(bus.cfg_ch) >= N_CH))
                     || (state != ST_IDLE);

    // NOTE: these register arrays are reset because software relies on a
    // known all-zero configuration after reset.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                delay_r[c] <= '0;
                width_r[c] <= '0;
                gap_r[c]   <= '0;
                rpt_r[c]   <= '0;
            end
            edge_tgt_r <= '0;
            trig_inv_r <= 1'b0;
            manual_r   <= 1'b0;
            cfg_err_q  <= 1'b0;
`ifdef GLITCH_SEQ_TIMEOUT_EN
            timeout_r  <= '0;
`endif
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so
            // every register samples pre-edge values.
            cfg_err_q <= bus.cfg_we && cfg_reject;
            if (bus.cfg_we && !cfg_reject) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (int'(bus.cfg_ch) == c) begin
                        case (bus.cfg_sel)
                            SEL_DELAY: delay_r[c] <= bus.cfg_wdata;
                            SEL_WIDTH: width_r[c] <= bus.cfg_wdata;
                            SEL_RPT:   rpt_r[c]   <= bus.cfg_wdata[RPT_W-1:0];
                            SEL_GAP:   gap_r[c]   <= bus.cfg_wdata;
                            default: ;
                        endcase
                    end
                end
                case (bus.cfg_sel)
                    SEL_EDGE_TGT: edge_tgt_r <= bus.cfg_wdata;
                    SEL_TRIG_CFG: begin
                        trig_inv_r <= bus.cfg_wdata[0];
                        manual_r   <= bus.cfg_wdata[1];
                    end
`ifdef GLITCH_SEQ_TIMEOUT_EN
                    SEL_TIMEOUT:  timeout_r <= bus.cfg_wdata;
`else
                    SEL_TIMEOUT: ;
`endif
                    default: ;
                endcase
            end
        end
    end

    // Two-stage synchroniser followed by a registered rising-edge detector
    assign trig_x = trig_s2 ^ trig_inv_r;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            trig_s1 <= bus.i_trig;
            trig_s2 <= trig_s1;
            trig_q  <= trig_x;
            edge_q  <= trig_x & ~trig_q;
        end
    end

    assign start = (state == ST_ARMED) && bus.i_arm
                && (manual_r || (edge_q && (edge_cnt == edge_tgt_r)));

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        edge_cnt_nxt = edge_cnt;
`ifdef GLITCH_SEQ_TIMEOUT_EN
        tmo_cnt_nxt  = tmo_cnt;
        timeout_nxt  = 1'b0;
`endif
        if (!bus.i_arm) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nxt    = ST_ARMED;
                    edge_cnt_nxt = '0;
`ifdef GLITCH_SEQ_TIMEOUT_EN
                    tmo_cnt_nxt  = CTR_W'(1);
`endif
                end
                ST_ARMED: begin
                    if (start) begin
                        state_nxt = ST_RUNNING;
                    end else begin
                        if (edge_q) edge_cnt_nxt = edge_cnt + CTR_W'(1);
`ifdef GLITCH_SEQ_TIMEOUT_EN
                        if (timeout_r != '0) begin
                            if (tmo_cnt == timeout_r) begin
                                state_nxt   = ST_DONE;
                                timeout_nxt = 1'b1;
                            end else begin
                                tmo_cnt_nxt = tmo_cnt + CTR_W'(1);
                            end
                        end
`endif
                    end
                end
                ST_RUNNING: if (all_fin_nxt) state_nxt = ST_DONE;
                ST_DONE: ;
            endcase
        end
    end

    // Per-channel pulse-train engines, reloaded when the sequence starts
    always_comb begin
        all_fin_nxt = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            ch_st_nxt[c]   = ch_st[c];
            ch_cnt_nxt[c]  = ch_cnt[c];
            ch_pcnt_nxt[c] = ch_pcnt[c];
            if (start) begin
                ch_cnt_nxt[c]  = CTR_W'(1);
                ch_pcnt_nxt[c] = '0;
                if (width_r[c] == '0)      ch_st_nxt[c] = CH_FIN;
                else if (delay_r[c] == '0) ch_st_nxt[c] = CH_FIRE;
                else                       ch_st_nxt[c] = CH_WAIT;
            end else if (state == ST_RUNNING) begin
                case (ch_st[c])
                    CH_WAIT: begin
                        if (ch_cnt[c] == delay_r[c]) begin
                            ch_st_nxt[c]  = CH_FIRE;
                            ch_cnt_nxt[c] = CTR_W'(1);
                        end else begin
                            ch_cnt_nxt[c] = ch_cnt[c] + CTR_W'(1);
                        end
                    end
                    CH_FIRE: begin
                        if (ch_cnt[c] == width_r[c]) begin
                            if (ch_pcnt[c] == rpt_r[c]) begin
                                ch_st_nxt[c] = CH_FIN;
                            end else begin
                                ch_st_nxt[c]   = CH_GAP;
                                ch_cnt_nxt[c]  = '0;
                                ch_pcnt_nxt[c] = ch_pcnt[c] + RPT_W'(1);
                            end
                        end else begin
                            ch_cnt_nxt[c] = ch_cnt[c] + CTR_W'(1);
                        end
                    end
                    CH_GAP: begin
                        if (ch_cnt[c] == gap_r[c]) begin
                            ch_st_nxt[c]  = CH_FIRE;
                            ch_cnt_nxt[c] = CTR_W'(1);
                        end else begin
                            ch_cnt_nxt[c] = ch_cnt[c] + CTR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
            if (ch_st_nxt[c] != CH_FIN) all_fin_nxt = 1'b0;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            edge_cnt <= '0;
            for (int c = 0; c < N_CH; c++) begin
                ch_st[c]   <= CH_FIN;
                ch_cnt[c]  <= '0;
                ch_pcnt[c] <= '0;
            end
`ifdef GLITCH_SEQ_TIMEOUT_EN
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            edge_cnt <= edge_cnt_nxt;
            for (int c = 0; c < N_CH; c++) begin
                ch_st[c]   <= ch_st_nxt[c];
                ch_cnt[c]  <= ch_cnt_nxt[c];
                ch_pcnt[c] <= ch_pcnt_nxt[c];
            end
`ifdef GLITCH_SEQ_TIMEOUT_EN
            tmo_cnt   <= tmo_cnt_nxt;
            timeout_q <= timeout_nxt;
`endif
        end
    end

    // Outputs are gated by RUNNING so an abort silences every channel at once
    always_comb begin
        glitch = '0;
        for (int c = 0; c < N_CH; c++) begin
            glitch[c] = (state == ST_RUNNING) && (ch_st[c] == CH_FIRE);
        end
    end

    assign bus.o_glitch  = glitch;
    assign bus.o_state   = state;
    assign bus.o_cfg_err = cfg_err_q;
`ifdef GLITCH_SEQ_TIMEOUT_EN
    assign bus.o_timeout = timeout_q;
`else
    assign bus.o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed scoreboard bench for glitch_sequencer: stimulus queues expected
// output events, a negedge monitor pops and compares each observed event.
module tb_glitch_sequencer;

    localparam int CTR_W = 32;
    localparam int N_CH  = 4;
    localparam int RPT_W = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef struct packed {
        int              cyc;
        logic [1:0]      st;
        logic [N_CH-1:0] gl;
        logic            err;
        logic            tmo;
    } ev_t;

    logic            sysclk = 1'b0;
    logic            rst;
    int              cyc = 0;
    int              n_total = 0;
    int              n_pass = 0;
    int              t;
    int              a;
    bit              mon_en = 1'b0;
    logic [1:0]      prev_st;
    logic [N_CH-1:0] prev_gl;
    ev_t             obs;
    ev_t             want;
    ev_t             exp_q[$];

    glitch_sequencer_if #(.CTR_W(CTR_W), .N_CH(N_CH)) bus ();

    glitch_sequencer #(.CTR_W(CTR_W), .N_CH(N_CH), .RPT_W(RPT_W)) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: an event is any change of state/glitch, or an err/timeout pulse
    always @(negedge sysclk) begin
        if (mon_en) begin
            obs.cyc = cyc;
            obs.st  = bus.o_state;
            obs.gl  = bus.o_glitch;
            obs.err = bus.o_cfg_err;
            obs.tmo = bus.o_timeout;
            if (obs.st != prev_st || obs.gl != prev_gl || obs.err || obs.tmo) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected event: cyc=%0d st=%0d gl=%b err=%b tmo=%b",
                             obs.cyc, obs.st, obs.gl, obs.err, obs.tmo);
                end else begin
                    want = exp_q.pop_front();
                    if (obs === want) n_pass++;
                    else $display("FAIL event: got cyc=%0d st=%0d gl=%b err=%b tmo=%b, expected cyc=%0d st=%0d gl=%b err=%b tmo=%b",
                                  obs.cyc, obs.st, obs.gl, obs.err, obs.tmo,
                                  want.cyc, want.st, want.gl, want.err, want.tmo);
                end
            end
            prev_st = obs.st;
            prev_gl = obs.gl;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic expect_ev(input int c, input logic [1:0] st, input logic [N_CH-1:0] gl,
                             input logic err, input logic tmo);
        exp_q.push_back('{cyc: c, st: st, gl: gl, err: err, tmo: tmo});
    endtask

    task automatic cfg_write(input int ch, input int sel, input logic [31:0] data,
                             input logic [1:0] st_now, input bit bad);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = 3'(ch);
        bus.cfg_sel   = 3'(sel);
        bus.cfg_wdata = data;
        if (bad) expect_ev(cyc + 1, st_now, '0, 1'b1, 1'b0);
        tick(1);
        bus.cfg_we = 1'b0;
    endtask

    task automatic arm();
        bus.i_arm = 1'b1;
        expect_ev(cyc + 1, S_ARM, '0, 1'b0, 1'b0);
        tick(1);
    endtask

    task automatic disarm();
        bus.i_arm = 1'b0;
        expect_ev(cyc + 1, S_IDLE, '0, 1'b0, 1'b0);
        tick(1);
    endtask

    initial begin
        bus.i_arm = 1'b0; bus.i_trig = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_ch = '0; bus.cfg_sel = '0; bus.cfg_wdata = '0;
        rst = 1'b1;
        tick(3);
        check("reset_state",   64'(bus.o_state),   64'(S_IDLE));
        check("reset_glitch",  64'(bus.o_glitch),  64'(0));
        check("reset_cfg_err", 64'(bus.o_cfg_err), 64'(0));
        check("reset_timeout", 64'(bus.o_timeout), 64'(0));
        rst = 1'b0;
        tick(2);
        prev_st = S_IDLE;
        prev_gl = '0;
        mon_en  = 1'b1;

        // Single channel: DELAY=5, WIDTH=3 -> high T+6..T+8, DONE at T+9
        cfg_write(0, 0, 5, S_IDLE, 0);
        cfg_write(0, 1, 3, S_IDLE, 0);
        arm(); tick(3);
        t = cyc + 3;
        bus.i_trig = 1'b1;
        expect_ev(t + 1, S_RUN,  4'b0000, 0, 0);
        expect_ev(t + 6, S_RUN,  4'b0001, 0, 0);
        expect_ev(t + 9, S_DONE, 4'b0000, 0, 0);
        tick(3); bus.i_trig = 1'b0; tick(12);
        disarm(); tick(3);

        // Repeat: ch1 WIDTH=2 RPT=2 GAP=1 -> three pulses, two low cycles between
        cfg_write(0, 1, 0, S_IDLE, 0);
        cfg_write(1, 1, 2, S_IDLE, 0);
        cfg_write(1, 2, 2, S_IDLE, 0);
        cfg_write(1, 3, 1, S_IDLE, 0);
        arm(); tick(3);
        t = cyc + 3;
        bus.i_trig = 1'b1;
        expect_ev(t + 1,  S_RUN,  4'b0010, 0, 0);
        expect_ev(t + 3,  S_RUN,  4'b0000, 0, 0);
        expect_ev(t + 5,  S_RUN,  4'b0010, 0, 0);
        expect_ev(t + 7,  S_RUN,  4'b0000, 0, 0);
        expect_ev(t + 9,  S_RUN,  4'b0010, 0, 0);
        expect_ev(t + 11, S_DONE, 4'b0000, 0, 0);
        tick(3); bus.i_trig = 1'b0; tick(12);
        disarm(); tick(3);

        // Edge count plus invert: EDGE_TGT=2, fires on the third falling edge only
        cfg_write(1, 1, 0, S_IDLE, 0);
        cfg_write(2, 0, 1, S_IDLE, 0);
        cfg_write(2, 1, 1, S_IDLE, 0);
        cfg_write(0, 4, 2, S_IDLE, 0);
        bus.i_trig = 1'b1; tick(4);
        cfg_write(0, 5, 1, S_IDLE, 0);
        tick(4);
        arm(); tick(3);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                t = cyc + 3;
                expect_ev(t + 1, S_RUN,  4'b0000, 0, 0);
                expect_ev(t + 2, S_RUN,  4'b0100, 0, 0);
                expect_ev(t + 3, S_DONE, 4'b0000, 0, 0);
            end
            bus.i_trig = 1'b0; tick(3);
            bus.i_trig = 1'b1; tick(3);
        end
        tick(3);
        disarm(); tick(2);
        bus.i_trig = 1'b0; tick(4);
        cfg_write(0, 5, 0, S_IDLE, 0);
        cfg_write(0, 4, 0, S_IDLE, 0);
        cfg_write(2, 1, 0, S_IDLE, 0);
        tick(4);

        // Abort mid-pulse, then re-arm and re-fire
        cfg_write(0, 0, 0, S_IDLE, 0);
        cfg_write(0, 1, 100, S_IDLE, 0);
        arm(); tick(3);
        t = cyc + 3;
        bus.i_trig = 1'b1;
        expect_ev(t + 1, S_RUN, 4'b0001, 0, 0);
        tick(3); bus.i_trig = 1'b0; tick(7);
        disarm(); tick(3);
        arm(); tick(3);
        t = cyc + 3;
        bus.i_trig = 1'b1;
        expect_ev(t + 1,   S_RUN,  4'b0001, 0, 0);
        expect_ev(t + 101, S_DONE, 4'b0000, 0, 0);
        tick(3); bus.i_trig = 1'b0; tick(102);
        disarm(); tick(3);

        // Config errors: bad channel, sel 7, writes while ARMED
        cfg_write(5, 4, 0, S_IDLE, 0);
        cfg_write(N_CH, 0, 7, S_IDLE, 1);
        cfg_write(0, 7, 0, S_IDLE, 1);
        cfg_write(0, 0, 2, S_IDLE, 0);
        cfg_write(0, 1, 1, S_IDLE, 0);
        arm(); tick(2);
        cfg_write(0, 1, 5, S_ARM, 1);
        cfg_write(0, 4, 3, S_ARM, 1);
        tick(2);
        t = cyc + 3;
        bus.i_trig = 1'b1;
        expect_ev(t + 1, S_RUN,  4'b0000, 0, 0);
        expect_ev(t + 3, S_RUN,  4'b0001, 0, 0);
        expect_ev(t + 4, S_DONE, 4'b0000, 0, 0);
        tick(3); bus.i_trig = 1'b0; tick(5);
        disarm(); tick(3);

        // Manual fire with overlapping channels 0 and 3
        cfg_write(0, 0, 0, S_IDLE, 0);
        cfg_write(0, 1, 3, S_IDLE, 0);
        cfg_write(3, 0, 1, S_IDLE, 0);
        cfg_write(3, 1, 3, S_IDLE, 0);
        cfg_write(0, 5, 2, S_IDLE, 0);
        tick(4);
        a = cyc;
        arm();
        expect_ev(a + 2, S_RUN,  4'b0001, 0, 0);
        expect_ev(a + 3, S_RUN,  4'b1001, 0, 0);
        expect_ev(a + 5, S_RUN,  4'b1000, 0, 0);
        expect_ev(a + 6, S_DONE, 4'b0000, 0, 0);
        tick(8);
        disarm(); tick(2);
        cfg_write(0, 5, 0, S_IDLE, 0);
        tick(4);

        // Arm timeout of 50 cycles with no trigger
        cfg_write(0, 6, 50, S_IDLE, 0);
        a = cyc;
        arm();
`ifdef GLITCH_SEQ_TIMEOUT_EN
        expect_ev(a + 51, S_DONE, 4'b0000, 0, 1);
`endif
        tick(60);
        disarm(); tick(5);

        mon_en = 1'b0;
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            n_total++;
            $display("FAIL missing event: got none, expected cyc=%0d st=%0d gl=%b err=%b tmo=%b",
                     want.cyc, want.st, want.gl, want.err, want.tmo);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
